ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Arbitrates the single-port data RAM between two requesters: port A (TINYCPU load/store) and port B (loader/DMA/debug).
Each requester sees a req/gnt command handshake and an rvalid read-return pulse. The block drives the RAM bus (addr, wdat, active-low rd_/wr_) from registered outputs.
It sits between TINYCPU's ram_* pins and the RAM instance in the top-level and the test bench.
Port A has fixed priority, with an anti-starvation limit for port B.

Parameters:
AW, 8, address width (RAM depth 2^AW)
DW, 8, data width
RD_LAT, 1, RAM read latency in cycles from the rd_-sampling edge to valid ram_rdat (legal 1..4)
STARVE_LIMIT, 4, max consecutive A grants while B waits before B is forced (legal 1..15)

Ports:
clk  in  1  single clock, rising edge
rst_  in  1  synchronous active-low reset
a_req / b_req  in  1  access request; hold stable until gnt seen
a_we / b_we  in  1  1 = write, 0 = read; qualified by req
a_addr / b_addr  in  AW  access address
a_wdat / b_wdat  in  DW  write data
a_gnt / b_gnt  out  1  one-cycle pulse: command is on the RAM bus this cycle
a_rvalid / b_rvalid  out  1  one-cycle pulse: rdat valid
a_rdat / b_rdat  out  DW  read data, held until next read return to that port
ram_addr  out  AW  RAM address
ram_wdat  out  DW  RAM write data
ram_rdat  in  DW  RAM read data
ram_rd_ / ram_wr_  out  1  active-low RAM strobes
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst_ low at a rising edge, any state):
  - state=IDLE; ram_rd_=ram_wr_=1; ram_addr=0, ram_wdat=0; gnts=0; rvalids=0; rdats=0; streak counter=0; owner=A.
  - An in-flight access is aborted; no rvalid is issued for it.
- States: IDLE, CMD, WAIT. All outputs are registered.
- IDLE, at a rising edge with any req high:
  - Winner selection:
    - Only A requesting: A.
    - Only B requesting: B.
    - Both requesting: A, unless streak==STARVE_LIMIT, then B.
  - Register the winner's addr/wdat onto ram_addr/ram_wdat.
  - Assert ram_wr_=0 if we, else ram_rd_=0. Set that port's gnt=1. Record owner. Go to CMD.
- IDLE with no req: remain in IDLE; strobes stay high.
- CMD (exactly one cycle; the strobe is low only in this cycle):
  - Next edge: strobes=1, gnt=0. ram_addr/ram_wdat are held.
  - Write: go to IDLE.
  - Read: go to WAIT with wait counter = RD_LAT-1.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0: capture ram_rdat into the owner's rdat, pulse the owner's rvalid for the following cycle, go to IDLE.
- req is ignored in CMD and WAIT. A requester drops or changes req at the edge ending its gnt cycle.
- Latency from the req-sampling edge E0:
  - Write: gnt and wr_ low in cycle E0..E1; back-to-back writes every 2 cycles.
  - Read: gnt in E0..E1; rvalid and rdat in cycle E(1+RD_LAT)..E(2+RD_LAT), coinciding with IDLE.
  - A new request can be accepted at the edge ending the rvalid cycle.
- Streak counter (4-bit):
  - Incremented on an A grant while b_req=1.
  - Cleared on any B grant, or on an A grant with b_req=0.
  - Saturates at STARVE_LIMIT.
- rdat of the non-owner port is unchanged. Only one of a_gnt/b_gnt and one of a_rvalid/b_rvalid may be high in any cycle.
- busy = (state != IDLE).

Test Plan:
- Reset: hold rst_=0 for 2 cycles with a_req=1 -> all gnts/rvalids 0, ram_rd_=ram_wr_=1, busy=0; first grant occurs at the first edge after rst_=1.
- A write: a_req=1, a_we=1, a_addr=8'h10, a_wdat=8'hA5 -> next cycle a_gnt=1, ram_wr_=0, ram_addr=10, ram_wdat=A5; the cycle after, ram_wr_=1 and busy=0; the RAM model holds A5 at address 10.
- B read, RD_LAT=1, RAM preloaded mem[8'h20]=8'h3C: b_req=1, b_we=0, b_addr=20 -> b_gnt with ram_rd_=0 at +1 cycle; b_rvalid=1 with b_rdat=3C at +3; a_rdat stays unchanged.
- Contention: a_req and b_req held high, A re-requesting immediately each time -> grant order A,A,A,A,B,A,A,A,A,B; b_req alone -> immediate B.
- Reset mid-read: assert rst_=0 during WAIT of an A read -> a_rvalid never pulses, state IDLE, and a subsequent B read completes normally.
- RD_LAT=3 build: A read of mem[8'hFF]=8'h81 -> a_rvalid at +5 cycles from the sampling edge, a_rdat=81; no second strobe is issued during WAIT.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes and RAM bus seen by ram_arbiter.
//   a_*/b_*   : req/we/addr/wdat in, gnt/rvalid/rdat out (per requester)
//   ram_*     : addr/wdat/active-low rd_/wr_ out, rdat in
//   busy      : arbiter not idle
// slave  : arbiter side.
// master : environment side (requesters plus RAM read data).
interface ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdat;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdat;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdat;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdat;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat;
    logic [DW-1:0] ram_rdat;
    logic          ram_rd_;
    logic          ram_wr_;
    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdat,
        input  b_req, b_we, b_addr, b_wdat,
        input  ram_rdat,
        output a_gnt, a_rvalid, a_rdat,
        output b_gnt, b_rvalid, b_rdat,
        output ram_addr, ram_wdat, ram_rd_, ram_wr_, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdat,
        output b_req, b_we, b_addr, b_wdat,
        output ram_rdat,
        input  a_gnt, a_rvalid, a_rdat,
        input  b_gnt, b_rvalid, b_rdat,
        input  ram_addr, ram_wdat, ram_rd_, ram_wr_, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between requester A (CPU, fixed
// priority) and requester B (loader/DMA/debug) with a starvation limit on B.
// Ports:
//   clk  : rising-edge clock
//   rst_ : synchronous active-low reset
//   bus  : ram_arbiter_if.slave (requester handshakes + RAM bus), all
//          outputs driven from registers
module ram_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_,
    ram_arbiter_if.slave bus
);
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;      // 0 = A, 1 = B
    logic [CW-1:0] wait_q, wait_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          a_gnt_q, a_gnt_d;
    logic          b_gnt_q, b_gnt_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdat_q, a_rdat_d;
    logic [DW-1:0] b_rdat_q, b_rdat_d;
    logic          busy_q, busy_d;
    logic          pick_b;
    logic          sel_we;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdat_q     <= '0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            wait_q     <= '0;
            streak_q   <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdat_q   <= '0;
            b_rdat_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            we_q       <= we_d;
            owner_q    <= owner_d;
            wait_q     <= wait_d;
            streak_q   <= streak_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdat_q   <= a_rdat_d;
            b_rdat_q   <= b_rdat_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        owner_d    = owner_q;
        wait_d     = wait_q;
        streak_d   = streak_q;
        a_rdat_d   = a_rdat_q;
        b_rdat_d   = b_rdat_q;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        pick_b     = 1'b0;
        sel_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // A wins ties unless B has waited out the streak limit.
                    pick_b  = bus.b_req && (!bus.a_req || (streak_q == SW'(STARVE_LIMIT)));
                    sel_we  = pick_b ? bus.b_we : bus.a_we;
                    addr_d  = pick_b ? bus.b_addr : bus.a_addr;
                    wdat_d  = pick_b ? bus.b_wdat : bus.a_wdat;
                    we_d    = sel_we;
                    owner_d = pick_b;
                    wr_n_d  = !sel_we;
                    rd_n_d  = sel_we;
                    a_gnt_d = !pick_b;
                    b_gnt_d = pick_b;
                    state_d = CMD;
                    if (pick_b || !bus.b_req) begin
                        streak_d = '0;
                    end else if (streak_q < SW'(STARVE_LIMIT)) begin
                        streak_d = SW'(streak_q + 1'b1);
                    end
                end
            end
            CMD: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    wait_d  = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    if (owner_q) begin
                        b_rdat_d   = bus.ram_rdat;
                        b_rvalid_d = 1'b1;
                    end else begin
                        a_rdat_d   = bus.ram_rdat;
                        a_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_wdat = wdat_q;
    assign bus.ram_rd_  = rd_n_q;
    assign bus.ram_wr_  = wr_n_q;
    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdat   = a_rdat_q;
    assign bus.b_rdat   = b_rdat_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with RD_LAT=1 (dut1) and
// RD_LAT=3 (dut3), each attached to a behavioural RAM.
module tb_ram_arbiter;
    logic clk;
    logic rst_;
    int   checks = 0;
    int   errors = 0;

    ram_arbiter_if #(.AW(8), .DW(8)) bus1 ();
    ram_arbiter_if #(.AW(8), .DW(8)) bus3 ();

    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .rst_(rst_), .bus(bus1.slave)
    );
    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst_(rst_), .bus(bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAMs: read data appears RD_LAT edges after the rd_-sampling edge and is
    // 8'hEE otherwise, so a capture on the wrong edge is visible.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] p1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (!bus1.ram_wr_) mem1[bus1.ram_addr] <= bus1.ram_wdat;
        p1 <= !bus1.ram_rd_ ? mem1[bus1.ram_addr] : 8'hEE;
        if (!bus3.ram_wr_) mem3[bus3.ram_addr] <= bus3.ram_wdat;
        p3[0] <= !bus3.ram_rd_ ? mem3[bus3.ram_addr] : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.ram_rdat = p1;
    assign bus3.ram_rdat = p3[2];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 8'h11; bus1.a_wdat = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({bus1.a_gnt, bus1.b_gnt, bus1.a_rvalid, bus1.b_rvalid, bus1.busy} !== 5'b0) begin
                errors++; $display("FAIL rst_flags: got %b expected 00000", {bus1.a_gnt, bus1.b_gnt, bus1.a_rvalid, bus1.b_rvalid, bus1.busy}); end
            checks++; if ({bus1.ram_rd_, bus1.ram_wr_, bus3.ram_rd_, bus3.ram_wr_} !== 4'b1111) begin
                errors++; $display("FAIL rst_strobes: got %b expected 1111", {bus1.ram_rd_, bus1.ram_wr_, bus3.ram_rd_, bus3.ram_wr_}); end
            checks++; if ({bus1.ram_addr, bus1.ram_wdat, bus1.a_rdat, bus1.b_rdat} !== 32'h0) begin
                errors++; $display("FAIL rst_regs: got %h expected 00000000", {bus1.ram_addr, bus1.ram_wdat, bus1.a_rdat, bus1.b_rdat}); end
        end
        rst_ = 1'b1;
        tick();
        checks++; if ({bus1.a_gnt, bus1.ram_wr_, bus1.busy} !== 3'b101) begin
            errors++; $display("FAIL rst_first_grant: got gnt/wr_/busy %b expected 101", {bus1.a_gnt, bus1.ram_wr_, bus1.busy}); end
        checks++; if ({bus1.ram_addr, bus1.ram_wdat} !== 16'h115A) begin
            errors++; $display("FAIL rst_first_bus: got %h expected 115a", {bus1.ram_addr, bus1.ram_wdat}); end
        bus1.a_req = 1'b0;
        tick();
        checks++; if ({bus1.a_gnt, bus1.ram_wr_, bus1.busy} !== 3'b010) begin
            errors++; $display("FAIL rst_first_done: got %b expected 010", {bus1.a_gnt, bus1.ram_wr_, bus1.busy}); end
    endtask

    task automatic test_a_write();
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 8'h10; bus1.a_wdat = 8'hA5;
        tick();
        checks++; if ({bus1.a_gnt, bus1.b_gnt, bus1.ram_wr_, bus1.ram_rd_, bus1.busy} !== 5'b10011) begin
            errors++; $display("FAIL awr_gnt: got %b expected 10011", {bus1.a_gnt, bus1.b_gnt, bus1.ram_wr_, bus1.ram_rd_, bus1.busy}); end
        checks++; if ({bus1.ram_addr, bus1.ram_wdat} !== 16'h10A5) begin
            errors++; $display("FAIL awr_bus: got %h expected 10a5", {bus1.ram_addr, bus1.ram_wdat}); end
        bus1.a_req = 1'b0;
        tick();
        checks++; if ({bus1.a_gnt, bus1.ram_wr_, bus1.busy} !== 3'b010) begin
            errors++; $display("FAIL awr_done: got %b expected 010", {bus1.a_gnt, bus1.ram_wr_, bus1.busy}); end
        checks++; if (mem1[8'h10] !== 8'hA5) begin
            errors++; $display("FAIL awr_mem: got %h expected a5", mem1[8'h10]); end
    endtask

    // B write 3C@20 on dut1 and A write 81@FF on dut3 load the RAMs for later reads.
    task automatic test_preload();
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 8'h20; bus1.b_wdat = 8'h3C;
        bus3.a_req = 1'b1; bus3.a_we = 1'b1; bus3.a_addr = 8'hFF; bus3.a_wdat = 8'h81;
        tick();
        checks++; if ({bus1.b_gnt, bus1.a_gnt, bus1.ram_wr_, bus3.a_gnt, bus3.ram_wr_} !== 5'b10010) begin
            errors++; $display("FAIL preload_gnt: got %b expected 10010", {bus1.b_gnt, bus1.a_gnt, bus1.ram_wr_, bus3.a_gnt, bus3.ram_wr_}); end
        bus1.b_req = 1'b0; bus3.a_req = 1'b0;
        tick();
        checks++; if ({mem1[8'h20], mem3[8'hFF]} !== 16'h3C81) begin
            errors++; $display("FAIL preload_mem: got %h expected 3c81", {mem1[8'h20], mem3[8'hFF]}); end
    endtask

    task automatic test_a_read();
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 8'h10;
        tick();
        checks++; if ({bus1.a_gnt, bus1.ram_rd_, bus1.ram_wr_, bus1.ram_addr} !== {3'b101, 8'h10}) begin
            errors++; $display("FAIL ard_gnt: got %b expected 10100010000", {bus1.a_gnt, bus1.ram_rd_, bus1.ram_wr_, bus1.ram_addr}); end
        bus1.a_req = 1'b0;
        tick();
        checks++; if ({bus1.a_rvalid, bus1.ram_rd_, bus1.busy} !== 3'b011) begin
            errors++; $display("FAIL ard_wait: got %b expected 011", {bus1.a_rvalid, bus1.ram_rd_, bus1.busy}); end
        tick();
        checks++; if ({bus1.a_rvalid, bus1.b_rvalid, bus1.busy, bus1.a_rdat} !== {3'b100, 8'hA5}) begin
            errors++; $display("FAIL ard_ret: got rvalids/busy %b rdat %h expected 100 a5", {bus1.a_rvalid, bus1.b_rvalid, bus1.busy}, bus1.a_rdat); end
        tick();
        checks++; if ({bus1.a_rvalid, bus1.a_rdat} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL ard_hold: got %b %h expected 0 a5", bus1.a_rvalid, bus1.a_rdat); end
    endtask

    task automatic test_b_read();
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 8'h20;
        tick();
        checks++; if ({bus1.b_gnt, bus1.a_gnt, bus1.ram_rd_, bus1.ram_addr} !== {3'b100, 8'h20}) begin
            errors++; $display("FAIL brd_gnt: got %b expected 10000100000", {bus1.b_gnt, bus1.a_gnt, bus1.ram_rd_, bus1.ram_addr}); end
        bus1.b_req = 1'b0;
        tick();
        checks++; if ({bus1.b_gnt, bus1.b_rvalid, bus1.ram_rd_, bus1.busy} !== 4'b0011) begin
            errors++; $display("FAIL brd_wait: got %b expected 0011", {bus1.b_gnt, bus1.b_rvalid, bus1.ram_rd_, bus1.busy}); end
        tick();
        checks++; if ({bus1.b_rvalid, bus1.a_rvalid, bus1.busy, bus1.b_rdat} !== {3'b100, 8'h3C}) begin
            errors++; $display("FAIL brd_ret: got rvalids/busy %b rdat %h expected 100 3c", {bus1.b_rvalid, bus1.a_rvalid, bus1.busy}, bus1.b_rdat); end
        checks++; if (bus1.a_rdat !== 8'hA5) begin
            errors++; $display("FAIL brd_a_rdat_kept: got %h expected a5", bus1.a_rdat); end
    endtask

    // Both hold writes: A,A,A,A,B,A,A,A,A,B; then B alone is served at the next slot.
    task automatic test_contention();
        bit exp_b [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int waited;
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 8'h30; bus1.a_wdat = 8'h01;
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 8'h31; bus1.b_wdat = 8'h02;
        for (int g = 0; g < 11; g++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!(bus1.a_gnt || bus1.b_gnt) && waited < 4);
            checks++; if ({bus1.a_gnt, bus1.b_gnt} !== (exp_b[g] ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL cont_order[%0d]: got a/b gnt %b expected %b", g, {bus1.a_gnt, bus1.b_gnt}, exp_b[g] ? 2'b01 : 2'b10); end
            checks++; if (waited != ((g == 0) ? 1 : 2)) begin
                errors++; $display("FAIL cont_spacing[%0d]: got %0d cycles expected %0d", g, waited, (g == 0) ? 1 : 2); end
            if (g == 9) bus1.a_req = 1'b0;
            if (g == 10) bus1.b_req = 1'b0;
        end
        tick();
        checks++; if ({bus1.busy, bus1.a_gnt, bus1.b_gnt} !== 3'b000) begin
            errors++; $display("FAIL cont_idle: got %b expected 000", {bus1.busy, bus1.a_gnt, bus1.b_gnt}); end
    endtask

    task automatic test_reset_mid_read();
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 8'h10;
        tick();
        bus1.a_req = 1'b0;
        tick();
        checks++; if (bus1.busy !== 1'b1) begin
            errors++; $display("FAIL rmid_in_wait: got busy %b expected 1", bus1.busy); end
        rst_ = 1'b0;
        tick();
        checks++; if ({bus1.a_rvalid, bus1.busy, bus1.ram_rd_, bus1.a_rdat} !== {3'b001, 8'h00}) begin
            errors++; $display("FAIL rmid_abort: got %b rdat %h expected 001 00", {bus1.a_rvalid, bus1.busy, bus1.ram_rd_}, bus1.a_rdat); end
        rst_ = 1'b1;
        tick();
        checks++; if ({bus1.a_rvalid, bus1.busy} !== 2'b00) begin
            errors++; $display("FAIL rmid_no_rvalid: got %b expected 00", {bus1.a_rvalid, bus1.busy}); end
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 8'h20;
        tick();
        checks++; if (bus1.b_gnt !== 1'b1) begin
            errors++; $display("FAIL rmid_b_gnt: got %b expected 1", bus1.b_gnt); end
        bus1.b_req = 1'b0;
        tick();
        tick();
        checks++; if ({bus1.b_rvalid, bus1.a_rvalid, bus1.b_rdat} !== {2'b10, 8'h3C}) begin
            errors++; $display("FAIL rmid_b_ret: got %b rdat %h expected 10 3c", {bus1.b_rvalid, bus1.a_rvalid}, bus1.b_rdat); end
        tick();
    endtask

    task automatic test_rdlat3();
        bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = 8'hFF;
        tick();
        checks++; if ({bus3.a_gnt, bus3.ram_rd_, bus3.ram_addr} !== {2'b10, 8'hFF}) begin
            errors++; $display("FAIL lat3_gnt: got %b expected 1011111111", {bus3.a_gnt, bus3.ram_rd_, bus3.ram_addr}); end
        bus3.a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus3.ram_rd_, bus3.ram_wr_, bus3.a_rvalid, bus3.busy} !== 4'b1101) begin
                errors++; $display("FAIL lat3_wait[%0d]: got %b expected 1101", i, {bus3.ram_rd_, bus3.ram_wr_, bus3.a_rvalid, bus3.busy}); end
        end
        tick();
        checks++; if ({bus3.a_rvalid, bus3.busy, bus3.a_rdat} !== {2'b10, 8'h81}) begin
            errors++; $display("FAIL lat3_ret: got %b rdat %h expected 10 81", {bus3.a_rvalid, bus3.busy}, bus3.a_rdat); end
        tick();
        checks++; if ({bus3.a_rvalid, bus3.a_rdat} !== {1'b0, 8'h81}) begin
            errors++; $display("FAIL lat3_hold: got %b %h expected 0 81", bus3.a_rvalid, bus3.a_rdat); end
    endtask

    initial begin
        rst_ = 1'b0;
        bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = '0; bus1.a_wdat = '0;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = '0; bus1.b_wdat = '0;
        bus3.a_req = 1'b0; bus3.a_we = 1'b0; bus3.a_addr = '0; bus3.a_wdat = '0;
        bus3.b_req = 1'b0; bus3.b_we = 1'b0; bus3.b_addr = '0; bus3.b_wdat = '0;
        test_reset();
        test_a_write();
        test_preload();
        test_a_read();
        test_b_read();
        test_contention();
        test_reset_mid_read();
        test_rdlat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
